ascon_decrypt_core: RTL and testbench

ASCON_DECRYPT_CORE -- requirements
Module: ascon_decrypt_core

---
 rtl/ascon_decrypt_core.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ascon_decrypt_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_decrypt_core.sv
// Ascon decryption core: 320-bit state, one permutation round per cycle.
// Define ASCON_DEC_TAG_OUT_EN to expose the computed tag on tag_o.

package ascon_pack;
    typedef logic [4:0][63:0] type_state;
endpackage

module constant_addition
    import ascon_pack::*;
(
    input  logic [3:0] round_i,
    input  type_state  state_i,
    output type_state  state_o
);
    logic [3:0] hi;
    assign hi = 4'hf - round_i;

    // round constant only touches word 2
    always_comb begin
        state_o    = state_i;
        state_o[2] = state_i[2] ^ {56'h0, hi, round_i};
    end
endmodule

module substitution_layer
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);
    type_state a, t, b;

    // bit-sliced 5-bit S-box across all 64 columns
    always_comb begin
        a    = state_i;
        a[0] = state_i[0] ^ state_i[4];
        a[4] = state_i[4] ^ state_i[3];
        a[2] = state_i[2] ^ state_i[1];
        t[0] = ~a[0] & a[1];
        t[1] = ~a[1] & a[2];
        t[2] = ~a[2] & a[3];
        t[3] = ~a[3] & a[4];
        t[4] = ~a[4] & a[0];
        b[0] = a[0] ^ t[1];
        b[1] = a[1] ^ t[2];
        b[2] = a[2] ^ t[3];
        b[3] = a[3] ^ t[4];
        b[4] = a[4] ^ t[0];
        state_o[0] = b[0] ^ b[4];
        state_o[1] = b[1] ^ b[0];
        state_o[2] = ~b[2];
        state_o[3] = b[3] ^ b[2];
        state_o[4] = b[4];
    end
endmodule

module diffusion
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);
    function automatic logic [63:0] ror(input logic [63:0] x,
                                        input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign state_o[0] = state_i[0] ^ ror(state_i[0], 19) ^ ror(state_i[0], 28);
    assign state_o[1] = state_i[1] ^ ror(state_i[1], 61) ^ ror(state_i[1], 39);
    assign state_o[2] = state_i[2] ^ ror(state_i[2], 1)  ^ ror(state_i[2], 6);
    assign state_o[3] = state_i[3] ^ ror(state_i[3], 10) ^ ror(state_i[3], 17);
    assign state_o[4] = state_i[4] ^ ror(state_i[4], 7)  ^ ror(state_i[4], 41);
endmodule

module ascon_decrypt_core
    import ascon_pack::*;
(
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  data_i,
    input  logic         data_valid_i,
    input  logic         data_last_i,
    output logic         data_ready_o,
    input  logic [127:0] tag_i,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
`ifdef ASCON_DEC_TAG_OUT_EN
    ,
    output logic [127:0] tag_o
`endif
);
    localparam logic [63:0] IV  = 64'h80400c0600000000;
    localparam logic [63:0] PAD = 64'h8000000000000000;

    typedef enum logic [2:0] {
        IDLE, INIT, AD_WAIT, AD_PERM, CT_WAIT, CT_PERM, FINAL, DONE
    } state_t;

    state_t      state_q, state_d;
    type_state   s_q, s_d, pre, s_ca, s_sl, post;
    logic [3:0]  cnt_q, cnt_d, rnd;
    logic        last_q, last_d;
    logic [63:0] plain_q, plain_d;
    logic        pv_q, pv_d;
    logic        ok_q, ok_d;
    logic        rnd_end;

    assign rnd_end       = (cnt_q == 4'd11);
    assign data_ready_o  = (state_q == AD_WAIT) || (state_q == CT_WAIT);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign plain_o       = plain_q;
    assign plain_valid_o = pv_q;
    assign tag_ok_o      = ok_q;

    // round input: absorb data / key into the state ahead of the round
    always_comb begin
        pre = s_q;
        rnd = cnt_q;
        unique case (state_q)
            AD_WAIT: begin
                pre[0] = s_q[0] ^ data_i;
                rnd    = 4'd6;
            end
            CT_WAIT: begin
                if (data_last_i) begin
                    pre[0] = data_i ^ PAD;
                    pre[1] = s_q[1] ^ key_i[127:64];
                    pre[2] = s_q[2] ^ key_i[63:0];
                    rnd    = 4'd0;
                end else begin
                    pre[0] = data_i;
                    rnd    = 4'd6;
                end
            end
            default: ;
        endcase
    end

    constant_addition  u_ca (.round_i(rnd), .state_i(pre),  .state_o(s_ca));
    substitution_layer u_sl (.state_i(s_ca), .state_o(s_sl));
    diffusion          u_df (.state_i(s_sl), .state_o(post));

    // next-state and datapath update
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        plain_d = plain_q;
        pv_d    = 1'b0;
        ok_d    = ok_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    s_d[0]  = IV;
                    s_d[1]  = key_i[127:64];
                    s_d[2]  = key_i[63:0];
                    s_d[3]  = nonce_i[127:64];
                    s_d[4]  = nonce_i[63:0];
                    cnt_d   = 4'd0;
                    ok_d    = 1'b0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_d   = post;
                cnt_d = cnt_q + 4'd1;
                if (rnd_end) begin
                    s_d[3]  = post[3] ^ key_i[127:64];
                    s_d[4]  = post[4] ^ key_i[63:0];
                    cnt_d   = 4'd0;
                    state_d = AD_WAIT;
                end
            end
            AD_WAIT: begin
                if (data_valid_i) begin
                    s_d     = post;
                    cnt_d   = 4'd7;
                    last_d  = data_last_i;
                    state_d = AD_PERM;
                end
            end
            AD_PERM: begin
                s_d   = post;
                cnt_d = cnt_q + 4'd1;
                if (rnd_end) begin
                    cnt_d = 4'd0;
                    if (last_q) begin
                        s_d[4]  = post[4] ^ 64'h1;
                        state_d = CT_WAIT;
                    end else begin
                        state_d = AD_WAIT;
                    end
                end
            end
            CT_WAIT: begin
                if (data_valid_i) begin
                    plain_d = s_q[0] ^ data_i;
                    pv_d    = 1'b1;
                    s_d     = post;
                    if (data_last_i) begin
                        cnt_d   = 4'd1;
                        state_d = FINAL;
                    end else begin
                        cnt_d   = 4'd7;
                        state_d = CT_PERM;
                    end
                end
            end
            CT_PERM, FINAL: begin
                s_d   = post;
                cnt_d = cnt_q + 4'd1;
                if (rnd_end) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == FINAL) ? DONE : CT_WAIT;
                end
            end
            DONE: begin
                ok_d    = (({s_q[3], s_q[4]} ^ key_i) == tag_i);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            plain_q <= '0;
            pv_q    <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            plain_q <= plain_d;
            pv_q    <= pv_d;
            ok_q    <= ok_d;
        end
    end

`ifdef ASCON_DEC_TAG_OUT_EN
    logic [127:0] tag_q;

    // computed tag captured on entry to DONE, held until next start
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tag_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            tag_q <= '0;
        end else if (state_q == FINAL && rnd_end) begin
            tag_q <= {post[3], post[4]} ^ key_i;
        end
    end

    assign tag_o = tag_q;
`endif
endmodule

// File: tb/tb_ascon_decrypt_core.sv
// Self-checking bench for ascon_decrypt_core with a column S-box
// reference model of the whole decryption.

module tb_ascon_decrypt_core;
    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [127:0] nonce_i = '0;
    logic [63:0]  data_i = '0;
    logic         data_valid_i = 1'b0;
    logic         data_last_i = 1'b0;
    logic         data_ready_o;
    logic [127:0] tag_i = '0;
    logic [63:0]  plain_o;
    logic         plain_valid_o;
    logic         busy_o;
    logic         done_o;
    logic         tag_ok_o;
`ifdef ASCON_DEC_TAG_OUT_EN
    logic [127:0] tag_o;
`endif

    ascon_decrypt_core dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .key_i        (key_i),
        .nonce_i      (nonce_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_last_i  (data_last_i),
        .data_ready_o (data_ready_o),
        .tag_i        (tag_i),
        .plain_o      (plain_o),
        .plain_valid_o(plain_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .tag_ok_o     (tag_ok_o)
`ifdef ASCON_DEC_TAG_OUT_EN
        ,
        .tag_o        (tag_o)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [127:0] KN = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        bit fixed;
        int nad;
        int nct;
        int gap;
        bit flip;
        bit poke;
        bit ok;
    } vec_t;

    vec_t         vt [6];
    logic [63:0]  mw [5];
    logic [63:0]  ad_q[$], ct_q[$], exp_pt[$], got_pt[$];
    logic [127:0] exp_tag;
    int           cyc = 0;
    int           start_cyc = 0;
    int           viol = 0;
    int           quiet = 0;
    bit           in_ct = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic mperm(input int first);
        logic [63:0] y [5];
        logic [4:0]  o;
        for (int r = first; r < 12; r++) begin
            mw[2] = mw[2] ^ 64'(240 - 15 * r);
            for (int b = 0; b < 64; b++) begin
                o = SBOX[{mw[0][b], mw[1][b], mw[2][b], mw[3][b], mw[4][b]}];
                y[0][b] = o[4];
                y[1][b] = o[3];
                y[2][b] = o[2];
                y[3][b] = o[1];
                y[4][b] = o[0];
            end
            mw[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
            mw[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
            mw[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
            mw[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
            mw[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        end
    endtask

    task automatic model(input logic [127:0] k, input logic [127:0] n);
        mw[0] = 64'h80400c0600000000;
        mw[1] = k[127:64];
        mw[2] = k[63:0];
        mw[3] = n[127:64];
        mw[4] = n[63:0];
        mperm(0);
        mw[3] ^= k[127:64];
        mw[4] ^= k[63:0];
        foreach (ad_q[i]) begin
            mw[0] ^= ad_q[i];
            mperm(6);
        end
        mw[4] ^= 64'h1;
        exp_pt.delete();
        foreach (ct_q[i]) begin
            exp_pt.push_back(mw[0] ^ ct_q[i]);
            if (i == ct_q.size() - 1) begin
                mw[0] = ct_q[i] ^ 64'h8000000000000000;
                mw[1] ^= k[127:64];
                mw[2] ^= k[63:0];
                mperm(0);
            end else begin
                mw[0] = ct_q[i];
                mperm(6);
            end
        end
        exp_tag = {mw[3], mw[4]} ^ k;
    endtask

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic [127:0] k, input logic [127:0] n);
        key_i   = k;
        nonce_i = n;
        start_i = 1'b1;
        tick();
        start_i   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send(input logic [63:0] d, input bit last);
        bit x;
        int w;
        w = 0;
        data_i       = d;
        data_last_i  = last;
        data_valid_i = 1'b1;
        do begin
            x = data_ready_o;
            tick();
            w++;
        end while (!x && w < 200);
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        check("xfer", 128'(x), 128'd1);
    endtask

    // protocol monitor: ready must stay low while a block is permuted
    always @(posedge clk) begin
        if (reset_i) begin
            quiet <= 0;
            in_ct <= 1'b0;
        end else if (data_valid_i && data_ready_o) begin
            quiet <= (in_ct && data_last_i) ? 12 : 5;
            if (data_last_i) in_ct <= 1'b1;
        end else if (quiet > 0) begin
            quiet <= quiet - 1;
        end
        if (start_i && !busy_o && !reset_i) in_ct <= 1'b0;
    end

    // plaintext capture and ready-window sampling mid-cycle
    always @(negedge clk) begin
        if (quiet > 0 && data_ready_o) viol <= viol + 1;
        if (plain_valid_o) got_pt.push_back(plain_o);
    end

    task automatic run_vec(input vec_t v);
        logic [127:0] k, n;
        int           w, v0;
        k = v.fixed ? KN : {$urandom, $urandom, $urandom, $urandom};
        n = v.fixed ? KN : {$urandom, $urandom, $urandom, $urandom};
        ad_q.delete();
        ct_q.delete();
        for (int i = 0; i < v.nad; i++)
            ad_q.push_back(v.fixed ? 64'h0001020304050607 + 64'(i)
                                   : {$urandom, $urandom});
        for (int i = 0; i < v.nct; i++)
            ct_q.push_back(v.fixed ? 64'h1011121314151617 + 64'(i)
                                   : {$urandom, $urandom});
        model(k, n);
        tag_i = exp_tag ^ (v.flip ? 128'h1 : 128'h0);
        got_pt.delete();
        v0 = viol;
        do_start(k, n);
        for (int i = 0; i < v.nad; i++) begin
            if (i > 0) repeat (v.gap) tick();
            send(ad_q[i], i == v.nad - 1);
        end
        if (v.poke) begin
            nonce_i = ~n;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            nonce_i = n;
        end
        for (int i = 0; i < v.nct; i++) begin
            repeat (v.gap) tick();
            send(ct_q[i], i == v.nct - 1);
        end
        w = 0;
        while (!done_o && w < 200) begin
            tick();
            w++;
        end
        check("done", 128'(done_o), 128'd1);
        if (v.gap == 0 && !v.poke)
            check("latency", 128'(cyc - start_cyc),
                  128'(12 + 6 * v.nad + 6 * (v.nct - 1) + 12));
`ifdef ASCON_DEC_TAG_OUT_EN
        check("tag_o_done", tag_o, exp_tag);
`endif
        tick();
        check("done_len", 128'(done_o), 128'd0);
        check("busy_end", 128'(busy_o), 128'd0);
        check("tag_ok", 128'(tag_ok_o), 128'(v.ok));
        check("pv_count", 128'(got_pt.size()), 128'(v.nct));
        foreach (exp_pt[i])
            check("plain", (i < got_pt.size()) ? 128'(got_pt[i]) : 128'hx,
                  128'(exp_pt[i]));
        check("ready_quiet", 128'(viol - v0), 128'd0);
        repeat (3) tick();
        check("tag_ok_hold", 128'(tag_ok_o), 128'(v.ok));
`ifdef ASCON_DEC_TAG_OUT_EN
        check("tag_o_hold", tag_o, exp_tag);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, 1, 1, 0, 0, 0, 1};
        vt[1] = '{1, 1, 1, 0, 1, 0, 0};
        vt[2] = '{0, 2, 3, 4, 0, 0, 1};
        vt[3] = '{0, 3, 2, 8, 0, 0, 1};
        vt[4] = '{0, 1, 2, 0, 0, 1, 1};
        vt[5] = '{0, 2, 1, 0, 1, 0, 0};

        repeat (3) tick();
        reset_i = 1'b0;
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_ready", 128'(data_ready_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        check("rst_pv", 128'(plain_valid_o), 128'd0);
        check("rst_plain", 128'(plain_o), 128'd0);
        check("rst_tag_ok", 128'(tag_ok_o), 128'd0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // reset in the third CT_PERM cycle
        do_start({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom}, 1'b1);
        send({$urandom, $urandom}, 1'b0);
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mid_busy", 128'(busy_o), 128'd0);
        check("mid_ready", 128'(data_ready_o), 128'd0);
        check("mid_done", 128'(done_o), 128'd0);
        check("mid_pv", 128'(plain_valid_o), 128'd0);
        check("mid_plain", 128'(plain_o), 128'd0);
        check("mid_tag_ok", 128'(tag_ok_o), 128'd0);
`ifdef ASCON_DEC_TAG_OUT_EN
        check("mid_tag_o", tag_o, 128'd0);
`endif
        tick();
        check("mid_idle", 128'(busy_o), 128'd0);
        run_vec(vt[2]);

        // reset wins over start in IDLE
        reset_i = 1'b1;
        start_i = 1'b1;
        tick();
        reset_i = 1'b0;
        start_i = 1'b0;
        check("rst_start_busy", 128'(busy_o), 128'd0);
        tick();
        check("rst_start_idle", 128'(busy_o), 128'd0);
        run_vec(vt[4]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
